// File: rtl/text_port_pkg.sv
// rtl/text_port_pkg.sv - shared types and constants for the text-port scheduler
package text_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_REG,
    ST_WAIT_REG,
    ST_EMIT,
    ST_NEXT_REG,
    ST_DONE
  } dump_state_t;

  localparam logic [7:0]  ASCII_ZERO       = 8'h30;
  localparam logic [7:0]  ASCII_A          = 8'h41;
  localparam logic [23:0] CHAR_ATTR        = 24'hFFFFFF;
  localparam int          DEFAULT_COLS     = 80;
  localparam int          DEFAULT_NUM_REGS = 32;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASCII_ZERO + {4'h0, nib}) : (ASCII_A + {4'h0, nib} - 8'd10);
  endfunction

endpackage

// File: rtl/text_port_scheduler_if.sv
// rtl/text_port_scheduler_if.sv - CPU request, dump control, debug read and text-buffer write signals
interface text_port_scheduler_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 13
) ();
  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic [ADDR_W-1:0]    cpu_req_addr;
  logic [WORD_SIZE-1:0] cpu_req_data;
  logic                 dump_start;
  logic                 dump_busy;
  logic                 dump_done;
  logic [4:0]           dbg_reg_addr;
  logic [WORD_SIZE-1:0] dbg_reg_data;
  logic                 ascii_write_en;
  logic [ADDR_W-1:0]    ascii_write_address;
  logic [WORD_SIZE-1:0] ascii_input;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_data, dump_start, dbg_reg_data,
    output cpu_req_ready, dump_busy, dump_done, dbg_reg_addr,
           ascii_write_en, ascii_write_address, ascii_input
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_data, dump_start, dbg_reg_data,
    input  cpu_req_ready, dump_busy, dump_done, dbg_reg_addr,
           ascii_write_en, ascii_write_address, ascii_input
  );
endinterface

// File: rtl/reg_dump_engine.sv
// rtl/reg_dump_engine.sv - walks the register file and renders each register as 8 hex characters
module reg_dump_engine
  import text_port_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 13,
  parameter int COLS      = DEFAULT_COLS,
  parameter int NUM_REGS  = DEFAULT_NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_dump_start,
  input  logic                 i_grant,
  input  logic [WORD_SIZE-1:0] i_dbg_reg_data,
  output logic                 o_req,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4:0]           o_dbg_reg_addr,
  output logic [ADDR_W-1:0]    o_addr,
  output logic [WORD_SIZE-1:0] o_data
);

  dump_state_t          r_state;
  dump_state_t          w_next;
  logic [4:0]           r_reg;
  logic [2:0]           r_nib;
  logic [WORD_SIZE-1:0] r_shadow;
  logic                 r_wait;
  logic [4:0]           r_dbg_addr;
  logic                 w_last_reg;
  logic [3:0]           w_nibble;

  assign w_last_reg = (r_reg == 5'(NUM_REGS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // WAIT_REG spans two cycles: the debug port is a synchronous read behind a registered address
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_dump_start) w_next = ST_SET_REG;
      ST_SET_REG:  w_next = ST_WAIT_REG;
      ST_WAIT_REG: if (r_wait) w_next = ST_EMIT;
      ST_EMIT:     if (i_grant && (r_nib == 3'd7)) w_next = ST_NEXT_REG;
      ST_NEXT_REG: w_next = w_last_reg ? ST_DONE : ST_SET_REG;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg      <= '0;
      r_nib      <= '0;
      r_shadow   <= '0;
      r_wait     <= 1'b0;
      r_dbg_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE:     if (i_dump_start) r_reg <= '0;
        ST_SET_REG: begin
          r_dbg_addr <= r_reg;
          r_wait     <= 1'b0;
        end
        ST_WAIT_REG: begin
          r_wait <= 1'b1;
          if (r_wait) begin
            r_shadow <= i_dbg_reg_data;
            r_nib    <= '0;
          end
        end
        ST_EMIT:     if (i_grant) r_nib <= r_nib + 3'd1;
        ST_NEXT_REG: if (!w_last_reg) r_reg <= r_reg + 5'd1;
        default: ;
      endcase
    end
  end

  assign w_nibble       = r_shadow[WORD_SIZE - 1 - 4 * int'(r_nib) -: 4];
  assign o_addr         = ADDR_W'(r_reg) * ADDR_W'(COLS) + ADDR_W'(r_nib);
  assign o_data         = WORD_SIZE'({hex_ascii(w_nibble), CHAR_ATTR});
  assign o_req          = (r_state == ST_EMIT);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = (r_state == ST_DONE);
  assign o_dbg_reg_addr = r_dbg_addr;

endmodule

// File: rtl/text_port_scheduler.sv
// rtl/text_port_scheduler.sv - arbitrates the text-buffer write port between CPU stores and the register dump
// Optional SCHED_FAIRNESS_EN: forces a dump grant after three consecutive CPU grants during EMIT.
module text_port_scheduler
  import text_port_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 13,
  parameter int COLS      = DEFAULT_COLS,
  parameter int NUM_REGS  = DEFAULT_NUM_REGS
) (
  input logic                   clk,
  input logic                   rst,
  text_port_scheduler_if.slave  bus
);

  logic                 w_dump_req;
  logic                 w_dump_grant;
  logic                 w_cpu_grant;
  logic                 w_force_dump;
  logic [ADDR_W-1:0]    w_dump_addr;
  logic [WORD_SIZE-1:0] w_dump_data;
  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [WORD_SIZE-1:0] r_wr_data;

  reg_dump_engine #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_W    (ADDR_W),
    .COLS      (COLS),
    .NUM_REGS  (NUM_REGS)
  ) u_dump (
    .clk            (clk),
    .rst            (rst),
    .i_dump_start   (bus.dump_start),
    .i_grant        (w_dump_grant),
    .i_dbg_reg_data (bus.dbg_reg_data),
    .o_req          (w_dump_req),
    .o_busy         (bus.dump_busy),
    .o_done         (bus.dump_done),
    .o_dbg_reg_addr (bus.dbg_reg_addr),
    .o_addr         (w_dump_addr),
    .o_data         (w_dump_data)
  );

`ifdef SCHED_FAIRNESS_EN
  logic [1:0] r_fair_cnt;

  assign w_force_dump = w_dump_req && (r_fair_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_fair_cnt <= 2'd0;
    else if (!w_dump_req || w_dump_grant)  r_fair_cnt <= 2'd0;
    else if (w_cpu_grant)                  r_fair_cnt <= r_fair_cnt + 2'd1;
  end
`else
  assign w_force_dump = 1'b0;
`endif

  assign w_cpu_grant       = bus.cpu_req_valid && !w_force_dump;
  assign w_dump_grant      = w_dump_req && !w_cpu_grant;
  assign bus.cpu_req_ready = w_cpu_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_cpu_grant || w_dump_grant;
      if (w_cpu_grant) begin
        r_wr_addr <= bus.cpu_req_addr;
        r_wr_data <= bus.cpu_req_data;
      end else if (w_dump_grant) begin
        r_wr_addr <= w_dump_addr;
        r_wr_data <= w_dump_data;
      end
    end
  end

  assign bus.ascii_write_en      = r_wr_en;
  assign bus.ascii_write_address = r_wr_addr;
  assign bus.ascii_input         = r_wr_data;

endmodule
